// File: rtl/uart_word_tx_pkg.sv
// Shared definitions for the word-serializing UART transmitter: state codes,
// divisor/width helpers and the frame-length helper. UART_TX_PARITY_EN adds a parity bit.
package uart_word_tx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    function automatic int calc_divisor(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int log2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int frame_bits();
`ifdef UART_TX_PARITY_EN
        return 11;
`else
        return 10;
`endif
    endfunction

    function automatic int frame_cycles(input int divisor);
        return frame_bits() * divisor;
    endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// Valid/ready word handshake into the UART transmitter.
interface uart_word_tx_if #(
    parameter int DataWidth = 32
);
    logic [DataWidth-1:0] DataIn;
    logic                 DataInValid;
    logic                 DataInReady;

    modport master (output DataIn, output DataInValid, input DataInReady);
    modport slave  (input DataIn, input DataInValid, output DataInReady);
endinterface

// File: rtl/uart_word_tx_baud_tick.sv
// Free-running bit-time counter: tick on the last cycle of each Divisor-cycle
// bit time; restart zeroes the count so a new bit time begins next cycle.
module uart_baud_tick
    import uart_word_tx_pkg::*;
#(
    parameter int Divisor = 868
) (
    input  logic Clock,
    input  logic Reset,
    input  logic restart,
    output logic tick
);
    localparam int CntW = log2w(Divisor);

    logic [CntW-1:0] cnt;

    assign tick = (cnt == CntW'(Divisor - 1));

    always_ff @(posedge Clock) begin
        if (!Reset || restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CntW'(1);
        end
    end
endmodule

// File: rtl/uart_word_tx.sv
// Sends a DataWidth-bit word as back-to-back 8N1 frames, LSB byte first.
// Defining UART_TX_PARITY_EN inserts an even-parity bit before each stop bit.
module uart_word_tx
    import uart_word_tx_pkg::*;
#(
    parameter int ClockFreq = 100_000_000,
    parameter int BaudRate  = 115200,
    parameter int DataWidth = 32
) (
    input  logic          Clock,
    input  logic          Reset,
    uart_word_tx_if.slave word,
    output logic          UARTTX,
    output logic          Busy
);
    localparam int Divisor  = calc_divisor(ClockFreq, BaudRate);
    localparam int NumBytes = DataWidth / 8;
    localparam int ByteW    = log2w(NumBytes);

    generate
        if (Divisor < 2) begin : g_bad_divisor
            $error("uart_word_tx: ClockFreq/BaudRate must be at least 2");
        end
        if ((DataWidth < 8) || ((DataWidth % 8) != 0)) begin : g_bad_width
            $error("uart_word_tx: DataWidth must be a nonzero multiple of 8");
        end
    endgenerate

    logic [2:0]           state, state_n;
    logic [2:0]           bit_idx, bit_n;
    logic [ByteW-1:0]     byte_idx, byte_n;
    logic [DataWidth-1:0] shreg, sh_n;
    logic [7:0]           cur_byte;
    logic                 tx_n;
    logic                 ready;
    logic                 tick;
    logic                 restart;

    assign word.DataInReady = ready;
    // Every state change begins a fresh bit time.
    assign restart = (state_n != state);

    uart_baud_tick #(
        .Divisor(Divisor)
    ) u_baud (
        .Clock  (Clock),
        .Reset  (Reset),
        .restart(restart),
        .tick   (tick)
    );

    always_comb begin
        state_n = state;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        sh_n    = shreg;
        case (state)
            ST_IDLE: begin
                if (word.DataInValid && ready) begin
                    state_n = ST_START;
                    sh_n    = word.DataIn;
                    byte_n  = '0;
                    bit_n   = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_n = ST_DATA;
                    bit_n   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_n = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (byte_idx == ByteW'(NumBytes - 1)) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_START;
                        sh_n    = shreg >> 8;
                        byte_n  = byte_idx + ByteW'(1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Output bit is decided from the next state so UARTTX stays registered.
    always_comb begin
        cur_byte = sh_n[7:0];
        tx_n     = 1'b1;
        case (state_n)
            ST_START: tx_n = 1'b0;
            ST_DATA:  tx_n = cur_byte[bit_n];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_n = ^cur_byte;
`endif
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            bit_idx  <= '0;
            byte_idx <= '0;
            UARTTX   <= 1'b1;
            ready    <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            state    <= state_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            UARTTX   <= tx_n;
            ready    <= (state_n == ST_IDLE);
            Busy     <= (state_n != ST_IDLE);
        end
    end

    always_ff @(posedge Clock) begin
        shreg <= sh_n;
    end
endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: 8-bit and 16-bit instances at Divisor 10,
// every transmitted cycle compared against hand-derived frame bits.
module tb_uart_word_tx;
    import uart_word_tx_pkg::*;

    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic Clock = 1'b0;
    logic Reset;
    logic tx8, busy8, tx16, busy16;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 Clock = ~Clock;

    uart_word_tx_if #(.DataWidth(8))  if8 ();
    uart_word_tx_if #(.DataWidth(16)) if16 ();

    uart_word_tx #(.ClockFreq(100), .BaudRate(10), .DataWidth(8)) dut8 (
        .Clock (Clock),
        .Reset (Reset),
        .word  (if8),
        .UARTTX(tx8),
        .Busy  (busy8)
    );

    uart_word_tx #(.ClockFreq(100), .BaudRate(10), .DataWidth(16)) dut16 (
        .Clock (Clock),
        .Reset (Reset),
        .word  (if16),
        .UARTTX(tx16),
        .Busy  (busy16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
        if (j == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic wait_ready(input bit sel);
        int n;
        int budget;
        n = 0;
        budget = 2 * frame_cycles(DIV) * 2 + 10;
        while (!(sel ? if16.DataInReady : if8.DataInReady) && n < budget) begin
            @(negedge Clock);
            n++;
        end
        if (n >= budget) check("wait_ready_timeout", 32'd0, 32'd1);
    endtask

    // Returns at the negedge of the first cycle after the acceptance edge.
    task automatic send(input bit sel, input logic [15:0] w, input bit hold);
        wait_ready(sel);
        if (sel) begin
            if16.DataIn = w;
            if16.DataInValid = 1'b1;
        end else begin
            if8.DataIn = w[7:0];
            if8.DataInValid = 1'b1;
        end
        @(negedge Clock);
        if (!hold) begin
            if16.DataInValid = 1'b0;
            if8.DataInValid = 1'b0;
        end
    endtask

    task automatic check_word(input bit sel, input logic [15:0] w, input int nbytes,
                              input bit toggle, input string tag);
        for (int b = 0; b < nbytes; b++) begin
            logic [7:0] by;
            by = (b == 0) ? w[7:0] : w[15:8];
            for (int j = 0; j < FRAME_BITS; j++) begin
                for (int c = 0; c < DIV; c++) begin
                    check({tag, "_tx"}, sel ? tx16 : tx8, exp_bit(by, j));
                    check({tag, "_rdy"}, sel ? if16.DataInReady : if8.DataInReady, 32'd0);
                    if (c == 0) check({tag, "_busy"}, sel ? busy16 : busy8, 32'd1);
                    if (toggle) if8.DataIn = 8'($urandom);
                    @(negedge Clock);
                end
            end
        end
        check({tag, "_rdy_end"}, sel ? if16.DataInReady : if8.DataInReady, 32'd1);
        check({tag, "_busy_end"}, sel ? busy16 : busy8, 32'd0);
        check({tag, "_tx_end"}, sel ? tx16 : tx8, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0;
        if8.DataIn = '0;
        if8.DataInValid = 1'b0;
        if16.DataIn = '0;
        if16.DataInValid = 1'b0;
        repeat (3) @(negedge Clock);
        check("rst_tx8", tx8, 32'd1);
        check("rst_rdy8", if8.DataInReady, 32'd0);
        check("rst_busy8", busy8, 32'd0);
        check("rst_tx16", tx16, 32'd1);
        check("rst_rdy16", if16.DataInReady, 32'd0);
        check("rst_busy16", busy16, 32'd0);
        Reset = 1'b1;
        @(negedge Clock);
        check("rel_rdy8", if8.DataInReady, 32'd1);
        check("rel_rdy16", if16.DataInReady, 32'd1);
        check("rel_busy8", busy8, 32'd0);

        // Single byte 0xA5: 0,1,0,1,0,0,1,0,1,1 and ready back at cycle 101.
        send(0, 16'h00A5, 0);
        check_word(0, 16'h00A5, 1, 0, "a5");

        // Two-byte word: 0x34 frame then 0x12 frame with no gap.
        send(1, 16'h1234, 0);
        check_word(1, 16'h1234, 2, 0, "w16");

        // Valid held high across two words.
        send(0, 16'h0000, 1);
        if8.DataIn = 8'hFF;
        check_word(0, 16'h0000, 1, 0, "b2b0");
        @(negedge Clock);
        if8.DataInValid = 1'b0;
        check_word(0, 16'h00FF, 1, 0, "b2b1");
        repeat (30) @(negedge Clock);
        check("b2b_idle_tx", tx8, 32'd1);
        check("b2b_idle_busy", busy8, 32'd0);

        // DataIn scrambled while the word is in flight.
        send(0, 16'h003C, 0);
        check_word(0, 16'h003C, 1, 1, "hold");
        if8.DataIn = 8'h00;

        // Reset in the middle of data bit 4 (cycles 51..60) of 0xC3.
        send(0, 16'h00C3, 0);
        repeat (54) @(negedge Clock);
        check("mid_tx_bit4", tx8, 32'd0);
        Reset = 1'b0;
        @(negedge Clock);
        check("abort_tx", tx8, 32'd1);
        check("abort_rdy", if8.DataInReady, 32'd0);
        check("abort_busy", busy8, 32'd0);
        repeat (2) @(negedge Clock);
        check("abort_rdy_hold", if8.DataInReady, 32'd0);
        check("abort_tx_hold", tx8, 32'd1);
        Reset = 1'b1;
        @(negedge Clock);
        check("abort_rel_rdy", if8.DataInReady, 32'd1);
        check("abort_rel_tx", tx8, 32'd1);

        // Parity pair: 0xA5 has even ones (parity 0), 0x07 odd ones (parity 1).
        send(0, 16'h00A5, 0);
        check_word(0, 16'h00A5, 1, 0, "par_a5");
        send(0, 16'h0007, 0);
        check_word(0, 16'h0007, 1, 0, "par_07");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
